// File: rtl/lf_osc_emul.sv
// rtl/lf_osc_emul.sv - low-frequency oscillator (LSOSC) emulation from a fast reference clock
// Optional feature macro: LSOSC_TRIM_EN (adds signed trim[3:0] half-period offset)
`timescale 1ns/1ps

module lf_osc_emul #(
  parameter int DIV_HALF = 2400,
  parameter int PU_DELAY = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CLKLFPU,
  input  logic       CLKLFEN,
`ifdef LSOSC_TRIM_EN
  input  logic [3:0] trim,
`endif
  output logic       CLKLF
);

  // Longest half-period the counter must cover (trim can add up to +7).
`ifdef LSOSC_TRIM_EN
  localparam int HALF_MAX = DIV_HALF + 7;
`else
  localparam int HALF_MAX = DIV_HALF;
`endif
  localparam int HW = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int PW = (PU_DELAY > 1) ? $clog2(PU_DELAY) : 1;

  typedef enum logic [1:0] {
    S_OFF,
    S_STARTUP,
    S_RUN
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pu_cnt, pu_cnt_n;
  logic [HW-1:0] half_cnt, half_cnt_n;
  logic [HW-1:0] term, term_n, term_new;
  logic          osc, osc_n;
  logic          en_q, en_n;
  logic          clk_lf_n;

`ifdef LSOSC_TRIM_EN
  int trimmed;

  // Terminal count for the next half-period: DIV_HALF + trim, never below one cycle.
  always_comb begin
    trimmed = DIV_HALF + int'($signed(trim));
    if (trimmed < 1) trimmed = 1;
    term_new = HW'(trimmed - 1);
  end
`else
  // Terminal count for a fixed half-period of DIV_HALF cycles.
  always_comb begin
    term_new = HW'(DIV_HALF - 1);
  end
`endif

  // Next-state, counters, oscillator and glitch-free output gate.
  always_comb begin
    state_n    = state;
    pu_cnt_n   = pu_cnt;
    half_cnt_n = half_cnt;
    term_n     = term;
    osc_n      = osc;
    en_n       = en_q;
    clk_lf_n   = 1'b0;

    if (!CLKLFPU) begin
      state_n    = S_OFF;
      pu_cnt_n   = '0;
      half_cnt_n = '0;
      osc_n      = 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          pu_cnt_n   = '0;
          half_cnt_n = '0;
          osc_n      = 1'b0;
          if (PU_DELAY == 0) begin
            state_n = S_RUN;
            term_n  = term_new;
          end else begin
            state_n = S_STARTUP;
          end
        end
        S_STARTUP: begin
          if (pu_cnt == PW'(PU_DELAY - 1)) begin
            state_n    = S_RUN;
            pu_cnt_n   = '0;
            half_cnt_n = '0;
            osc_n      = 1'b0;
            term_n     = term_new;
          end else begin
            pu_cnt_n = pu_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (half_cnt == term) begin
            half_cnt_n = '0;
            osc_n      = ~osc;
            term_n     = term_new;
          end else begin
            half_cnt_n = half_cnt + 1'b1;
          end
        end
        default: begin
          state_n    = S_OFF;
          pu_cnt_n   = '0;
          half_cnt_n = '0;
          osc_n      = 1'b0;
        end
      endcase
    end

    // The enable only moves while osc is low or on the edge it falls, so a
    // high phase is never cut short and never starts mid-phase.
    if (!CLKLFPU) begin
      en_n = 1'b0;
    end else if (!(osc && osc_n)) begin
      en_n = CLKLFEN;
    end

    clk_lf_n = osc_n & en_n;
  end

  // State and datapath registers; reset forces the oscillator off immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      pu_cnt   <= '0;
      half_cnt <= '0;
      term     <= '0;
      osc      <= 1'b0;
      en_q     <= 1'b0;
      CLKLF    <= 1'b0;
    end else begin
      state    <= state_n;
      pu_cnt   <= pu_cnt_n;
      half_cnt <= half_cnt_n;
      term     <= term_n;
      osc      <= osc_n;
      en_q     <= en_n;
      CLKLF    <= clk_lf_n;
    end
  end

endmodule

// File: tb/tb_lf_osc_emul.sv
// tb/tb_lf_osc_emul.sv - scoreboard bench for lf_osc_emul (DIV_HALF=4, PU_DELAY=3)
`timescale 1ns/1ps

module tb_lf_osc_emul;

  logic clk = 1'b0;
  logic rst_n;
  logic pu;
  logic en;
`ifdef LSOSC_TRIM_EN
  logic [3:0] trim;
`endif
  logic clk_lf;

  typedef struct {
    logic  exp;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  lf_osc_emul #(
    .DIV_HALF(4),
    .PU_DELAY(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .CLKLFPU(pu),
    .CLKLFEN(en),
`ifdef LSOSC_TRIM_EN
    .trim   (trim),
`endif
    .CLKLF  (clk_lf)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: CLKLF=%b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected oscillator level k edges after the PU-sampling edge.
  function automatic logic grid(input int k, input int first, input int h);
    return (k >= first) && (((k - first) % (2 * h)) < h);
  endfunction

  // Drive inputs for the next edge, then record what CLKLF must be after it.
  task automatic cyc(input logic p, input logic e, input logic x, input string name);
    pu = p;
    en = e;
    @(posedge clk);
    #1;
    sb.push_back('{x, name});
  endtask

  // Monitor: compare CLKLF against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check(mon_e.name, clk_lf, mon_e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic e_in;
    rst_n = 1'b0;
    pu    = 1'b0;
    en    = 1'b0;
`ifdef LSOSC_TRIM_EN
    trim  = 4'd0;
`endif
    repeat (3) cyc(1'b0, 1'b0, 1'b0, "rst_hold");
    rst_n = 1'b1;

    repeat (50) cyc(1'b0, 1'b1, 1'b0, "t1_off");

    // Power up with enable: rise at edge 7, period 8. Enable dropped in the
    // second cycle of the high phase at 39 and restored during the high at 55.
    for (int k = 0; k < 72; k++) begin
      e_in = !(k >= 40 && k < 57);
      cyc(1'b1, e_in, grid(k, 7, 4) && !(k >= 43 && k < 63), $sformatf("t23_k%0d", k));
    end

    // Power removed during the high phase starting at 71.
    repeat (4) cyc(1'b0, 1'b1, 1'b0, "t4_pu_drop");
    for (int k = 0; k < 25; k++) begin
      cyc(1'b1, 1'b1, grid(k, 7, 4), $sformatf("t4_k%0d", k));
    end

    // Asynchronous reset between edges while CLKLF is high.
    #6;
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", clk_lf, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, "t5_in_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 21; k++) begin
      cyc(1'b1, 1'b1, grid(k, 7, 4), $sformatf("t5_k%0d", k));
    end

`ifdef LSOSC_TRIM_EN
    repeat (2) cyc(1'b0, 1'b1, 1'b0, "t6_off_a");
    trim = 4'b1110;
    for (int k = 0; k < 21; k++) begin
      cyc(1'b1, 1'b1, grid(k, 5, 2), $sformatf("t6_m2_k%0d", k));
    end
    repeat (2) cyc(1'b0, 1'b1, 1'b0, "t6_off_b");
    trim = 4'b1011;
    for (int k = 0; k < 21; k++) begin
      cyc(1'b1, 1'b1, grid(k, 4, 1), $sformatf("t6_m5_k%0d", k));
    end
`endif

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
